// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// mem_stage_if : EX/MEM fields, SRAM response and MEM/WB outputs of mem_stage
// Revision: 1.0
// ============================================================================
interface mem_stage_if;
  logic        mem_flush_i;
  logic        mem_stall_i;
  logic        mem_wren_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic [7:0]  mem_memop_i;
  logic        mem_inst_load_i;
  logic [1:0]  mem_memaddr_low_i;
  logic        mem_nofwd_i;
  logic [31:0] mem_pc_i;
  logic [31:0] mem_inst_i;
  logic        mem_inslot_i;
  logic [31:0] data_sram_rdata_i;
  logic        data_rvalid_i;
  logic        mem_stallreq_o;
  logic [31:0] mem_wdata_bp_o;
  logic        mem_nofwd_bp_o;
  logic        wb_wren_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic [31:0] wb_pc_o;
  logic [31:0] wb_inst_o;
  logic        wb_inslot_o;

  modport master (
    output mem_flush_i, mem_stall_i, mem_wren_i, mem_waddr_i, mem_wdata_i,
           mem_memop_i, mem_inst_load_i, mem_memaddr_low_i, mem_nofwd_i,
           mem_pc_i, mem_inst_i, mem_inslot_i, data_sram_rdata_i, data_rvalid_i,
    input  mem_stallreq_o, mem_wdata_bp_o, mem_nofwd_bp_o, wb_wren_o,
           wb_waddr_o, wb_wdata_o, wb_pc_o, wb_inst_o, wb_inslot_o
  );

  modport slave (
    input  mem_flush_i, mem_stall_i, mem_wren_i, mem_waddr_i, mem_wdata_i,
           mem_memop_i, mem_inst_load_i, mem_memaddr_low_i, mem_nofwd_i,
           mem_pc_i, mem_inst_i, mem_inslot_i, data_sram_rdata_i, data_rvalid_i,
    output mem_stallreq_o, mem_wdata_bp_o, mem_nofwd_bp_o, wb_wren_o,
           wb_waddr_o, wb_wdata_o, wb_pc_o, wb_inst_o, wb_inslot_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : load data extraction, load-response wait/buffer FSM, MEM/WB regs
// Revision: 1.0
// ============================================================================
module mem_stage (
  input wire logic   clk,
  input wire logic   rst_n,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_buf;
  logic        r_wb_wren;
  logic [4:0]  r_wb_waddr;
  logic [31:0] r_wb_wdata;
  logic [31:0] r_wb_pc;
  logic [31:0] r_wb_inst;
  logic        r_wb_inslot;

  logic        w_ld;
  logic        w_avail;
  logic [31:0] w_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_res;

  assign w_ld    = bus.mem_inst_load_i;
  assign w_avail = (r_state == S_HOLD) | ((r_state == S_IDLE) & bus.data_rvalid_i);
  assign w_src   = (r_state == S_HOLD) ? r_buf : bus.data_sram_rdata_i;
  assign w_half  = bus.mem_memaddr_low_i[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    w_byte = w_src[7:0];
    case (bus.mem_memaddr_low_i)
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
  end

  always_comb begin
    w_ext = w_src;
    if (bus.mem_memop_i[0])
      w_ext = {{24{w_byte[7]}}, w_byte};
    else if (bus.mem_memop_i[1])
      w_ext = {24'd0, w_byte};
    else if (bus.mem_memop_i[2])
      w_ext = {{16{w_half[15]}}, w_half};
    else if (bus.mem_memop_i[3])
      w_ext = {16'd0, w_half};
  end

  assign w_res = w_ld ? w_ext : bus.mem_wdata_i;

  assign bus.mem_wdata_bp_o = w_res;
  assign bus.mem_nofwd_bp_o = bus.mem_nofwd_i | (w_ld & ~w_avail);
  assign bus.mem_stallreq_o = w_ld & ~w_avail & ~bus.mem_flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_wb_wren   <= 1'b0;
      r_wb_waddr  <= '0;
      r_wb_wdata  <= '0;
      r_wb_pc     <= '0;
      r_wb_inst   <= '0;
      r_wb_inslot <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A flushed load whose response is still outstanding must swallow it later.
          if (bus.mem_flush_i) begin
            if (w_ld & ~bus.data_rvalid_i)
              r_state <= S_DROP;
          end else if (w_ld & bus.data_rvalid_i & bus.mem_stall_i) begin
            r_state <= S_HOLD;
            r_buf   <= bus.data_sram_rdata_i;
          end
        end
        S_HOLD: begin
          if (bus.mem_flush_i) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
          end else if (!bus.mem_stall_i) begin
            r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (!bus.mem_flush_i && bus.data_rvalid_i)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (bus.mem_flush_i) begin
        r_wb_wren   <= 1'b0;
        r_wb_waddr  <= '0;
        r_wb_wdata  <= '0;
        r_wb_pc     <= '0;
        r_wb_inst   <= '0;
        r_wb_inslot <= 1'b0;
      end else if (!bus.mem_stall_i) begin
        r_wb_wren   <= bus.mem_wren_i;
        r_wb_waddr  <= bus.mem_waddr_i;
        r_wb_wdata  <= w_res;
        r_wb_pc     <= bus.mem_pc_i;
        r_wb_inst   <= bus.mem_inst_i;
        r_wb_inslot <= bus.mem_inslot_i;
      end
    end
  end

  assign bus.wb_wren_o   = r_wb_wren;
  assign bus.wb_waddr_o  = r_wb_waddr;
  assign bus.wb_wdata_o  = r_wb_wdata;
  assign bus.wb_pc_o     = r_wb_pc;
  assign bus.wb_inst_o   = r_wb_inst;
  assign bus.wb_inslot_o = r_wb_inslot;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : directed vector table plus hand-written multi-cycle sequences
// Revision: 1.0
// ============================================================================
module tb_mem_stage;

  logic clk;
  logic rst_n;
  logic r_ext_stall;
  int   n_checks;
  int   n_errors;

  mem_stage_if bus ();

  mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Controller model: stall follows the stage's own request plus any external stall.
  assign bus.mem_stall_i = r_ext_stall | bus.mem_stallreq_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [7:0]  memop;
    logic [1:0]  low;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  localparam logic [7:0] OP_LB  = 8'h01;
  localparam logic [7:0] OP_LBU = 8'h02;
  localparam logic [7:0] OP_LH  = 8'h04;
  localparam logic [7:0] OP_LHU = 8'h08;
  localparam logic [7:0] OP_LW  = 8'h10;
  localparam logic [7:0] OP_SW  = 8'h80;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_flush_i       = 1'b0;
    bus.mem_wren_i        = 1'b0;
    bus.mem_waddr_i       = '0;
    bus.mem_wdata_i       = '0;
    bus.mem_memop_i       = '0;
    bus.mem_inst_load_i   = 1'b0;
    bus.mem_memaddr_low_i = '0;
    bus.mem_nofwd_i       = 1'b0;
    bus.mem_pc_i          = '0;
    bus.mem_inst_i        = '0;
    bus.mem_inslot_i      = 1'b0;
    bus.data_sram_rdata_i = '0;
    bus.data_rvalid_i     = 1'b0;
    r_ext_stall           = 1'b0;
  endtask

  task automatic load(input logic [7:0] op, input logic [1:0] low, input logic [31:0] pc);
    bus.mem_inst_load_i   = 1'b1;
    bus.mem_memop_i       = op;
    bus.mem_memaddr_low_i = low;
    bus.mem_wren_i        = 1'b1;
    bus.mem_waddr_i       = 5'd9;
    bus.mem_pc_i          = pc;
    bus.mem_inst_i        = 32'h8C09_0000;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0]  = '{1'b1, OP_LB,  2'd3, 32'h80FF_1234, 1'b1, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b1, OP_LBU, 2'd3, 32'h80FF_1234, 1'b1, 32'h0, 32'h0000_0080};
    vecs[2]  = '{1'b1, OP_LB,  2'd0, 32'h80FF_1234, 1'b1, 32'h0, 32'h0000_0034};
    vecs[3]  = '{1'b1, OP_LB,  2'd1, 32'h80FF_1234, 1'b1, 32'h0, 32'h0000_0012};
    vecs[4]  = '{1'b1, OP_LB,  2'd2, 32'h80FF_1234, 1'b1, 32'h0, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b1, OP_LBU, 2'd2, 32'h80FF_1234, 1'b1, 32'h0, 32'h0000_00FF};
    vecs[6]  = '{1'b1, OP_LH,  2'd0, 32'h80FF_9234, 1'b1, 32'h0, 32'hFFFF_9234};
    vecs[7]  = '{1'b1, OP_LHU, 2'd0, 32'h80FF_9234, 1'b1, 32'h0, 32'h0000_9234};
    vecs[8]  = '{1'b1, OP_LH,  2'd2, 32'h80FF_9234, 1'b1, 32'h0, 32'hFFFF_80FF};
    vecs[9]  = '{1'b1, OP_LW,  2'd0, 32'h80FF_9234, 1'b1, 32'h0, 32'h80FF_9234};
    vecs[10] = '{1'b0, 8'h00,  2'd0, 32'h1234_5678, 1'b0, 32'h5,  32'h0000_0005};
    vecs[11] = '{1'b0, OP_SW,  2'd0, 32'h0,         1'b0, 32'hCAFE, 32'h0000_CAFE};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("reset wb_wdata", bus.wb_wdata_o, 32'h0);
    chk("reset wb_wren", {31'd0, bus.wb_wren_o}, 32'h0);
    chk("reset wb_pc", bus.wb_pc_o, 32'h0);
    chk("reset stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      bus.mem_inst_load_i   = vecs[i].ld;
      bus.mem_memop_i       = vecs[i].memop;
      bus.mem_memaddr_low_i = vecs[i].low;
      bus.data_sram_rdata_i = vecs[i].rdata;
      bus.data_rvalid_i     = vecs[i].rvalid;
      bus.mem_wdata_i       = vecs[i].wdata;
      bus.mem_wren_i        = 1'b1;
      bus.mem_waddr_i       = 5'(i + 1);
      bus.mem_pc_i          = 32'h1000 + 32'(4 * i);
      #1;
      chk($sformatf("vec%0d stallreq", i), {31'd0, bus.mem_stallreq_o}, 32'h0);
      chk($sformatf("vec%0d bypass", i), bus.mem_wdata_bp_o, vecs[i].exp);
      tick();
      chk($sformatf("vec%0d wb_wdata", i), bus.wb_wdata_o, vecs[i].exp);
      chk($sformatf("vec%0d wb_waddr", i), {27'd0, bus.wb_waddr_o}, 32'(i + 1));
      chk($sformatf("vec%0d wb_pc", i), bus.wb_pc_o, 32'h1000 + 32'(4 * i));
    end

    // lhu with response three cycles late
    idle_inputs();
    load(OP_LHU, 2'd2, 32'h2000);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("late c%0d stallreq", c), {31'd0, bus.mem_stallreq_o}, 32'h1);
      chk($sformatf("late c%0d nofwd_bp", c), {31'd0, bus.mem_nofwd_bp_o}, 32'h1);
      tick();
      chk($sformatf("late c%0d wb hold", c), bus.wb_wdata_o, 32'h0000_CAFE);
    end
    bus.data_sram_rdata_i = 32'h9ABC_0000;
    bus.data_rvalid_i     = 1'b1;
    #1;
    chk("late arrive stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    tick();
    chk("late wb_wdata", bus.wb_wdata_o, 32'h0000_9ABC);
    chk("late wb_wren", {31'd0, bus.wb_wren_o}, 32'h1);

    // lw response lands under external stall and must be buffered
    idle_inputs();
    load(OP_LW, 2'd0, 32'h3000);
    r_ext_stall           = 1'b1;
    bus.data_sram_rdata_i = 32'hDEAD_BEEF;
    bus.data_rvalid_i     = 1'b1;
    #1;
    chk("hold entry stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    tick();
    bus.data_sram_rdata_i = 32'h0;
    bus.data_rvalid_i     = 1'b0;
    #1;
    chk("hold stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    chk("hold bypass", bus.mem_wdata_bp_o, 32'hDEAD_BEEF);
    chk("hold nofwd_bp", {31'd0, bus.mem_nofwd_bp_o}, 32'h0);
    tick();
    chk("hold wb held", bus.wb_wdata_o, 32'h0000_9ABC);
    r_ext_stall = 1'b0;
    tick();
    chk("hold wb_wdata", bus.wb_wdata_o, 32'hDEAD_BEEF);
    chk("hold wb_pc", bus.wb_pc_o, 32'h3000);

    // flush a waiting load; stale response then the new load's response
    idle_inputs();
    load(OP_LW, 2'd0, 32'h4000);
    #1;
    chk("flush wait stallreq", {31'd0, bus.mem_stallreq_o}, 32'h1);
    tick();
    bus.mem_flush_i = 1'b1;
    #1;
    chk("flush stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    tick();
    chk("flush wb_wdata", bus.wb_wdata_o, 32'h0);
    chk("flush wb_wren", {31'd0, bus.wb_wren_o}, 32'h0);
    chk("flush wb_pc", bus.wb_pc_o, 32'h0);
    bus.mem_flush_i = 1'b0;
    load(OP_LW, 2'd0, 32'h4010);
    bus.data_sram_rdata_i = 32'h1111_1111;
    bus.data_rvalid_i     = 1'b1;
    #1;
    chk("drop stallreq", {31'd0, bus.mem_stallreq_o}, 32'h1);
    chk("drop nofwd_bp", {31'd0, bus.mem_nofwd_bp_o}, 32'h1);
    tick();
    chk("drop wb held", bus.wb_wdata_o, 32'h0);
    bus.data_sram_rdata_i = 32'h2222_2222;
    #1;
    chk("after drop stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    tick();
    chk("after drop wb_wdata", bus.wb_wdata_o, 32'h2222_2222);
    chk("after drop wb_pc", bus.wb_pc_o, 32'h4010);

    // flush coinciding with rvalid in IDLE discards the response, no DROP
    load(OP_LW, 2'd0, 32'h4100);
    bus.data_sram_rdata_i = 32'h5555_5555;
    bus.mem_flush_i       = 1'b1;
    tick();
    chk("flush+rvalid wb_wdata", bus.wb_wdata_o, 32'h0);
    bus.mem_flush_i       = 1'b0;
    bus.data_sram_rdata_i = 32'h0000_0033;
    #1;
    chk("flush+rvalid next stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    tick();
    chk("flush+rvalid next wb", bus.wb_wdata_o, 32'h0000_0033);

    // non-load held by stall for two cycles
    idle_inputs();
    bus.mem_wren_i  = 1'b1;
    bus.mem_wdata_i = 32'h5;
    bus.mem_pc_i    = 32'h5000;
    r_ext_stall     = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("alu c%0d bypass", c), bus.mem_wdata_bp_o, 32'h5);
      tick();
      chk($sformatf("alu c%0d wb hold", c), bus.wb_wdata_o, 32'h0000_0033);
    end
    r_ext_stall = 1'b0;
    #1;
    chk("alu bypass", bus.mem_wdata_bp_o, 32'h5);
    tick();
    chk("alu wb_wdata", bus.wb_wdata_o, 32'h5);
    chk("alu wb_pc", bus.wb_pc_o, 32'h5000);

    // asynchronous reset while a response is buffered
    idle_inputs();
    load(OP_LW, 2'd0, 32'h6000);
    r_ext_stall           = 1'b1;
    bus.data_sram_rdata_i = 32'h1234_5678;
    bus.data_rvalid_i     = 1'b1;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("areset wb_wdata", bus.wb_wdata_o, 32'h0);
    chk("areset wb_wren", {31'd0, bus.wb_wren_o}, 32'h0);
    chk("areset wb_pc", bus.wb_pc_o, 32'h0);
    chk("areset stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    #1;
    rst_n = 1'b1;
    bus.data_sram_rdata_i = 32'hBAD0_BAD0;
    bus.data_rvalid_i     = 1'b1;
    bus.mem_wren_i        = 1'b1;
    bus.mem_wdata_i       = 32'h77;
    #1;
    chk("stray stallreq", {31'd0, bus.mem_stallreq_o}, 32'h0);
    tick();
    chk("stray wb_wdata", bus.wb_wdata_o, 32'h77);
    bus.data_rvalid_i = 1'b0;
    tick();
    chk("stray then idle", bus.wb_wdata_o, 32'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
